mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 multiplexer.
- Four requesters each present a data word and a request line. The block decides which one owns the mux, drives the 2-bit select, and produces the registered grant plus the muxed output.
- Sits directly in front of the 4:1 mux and replaces hand-driven select stimulus with fair, starvation-free sharing.

Parameters:
- DW, 1, width of each data input and of out.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant while any other requester is waiting. Legal range is 1 to 255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[0] belongs to a, req[1] to b, req[2] to c, req[3] to d.
- a  input  DW  data from requester 0.
- b  input  DW  data from requester 1.
- c  input  DW  data from requester 2.
- d  input  DW  data from requester 3.
- sel  output  2  registered mux select; index of the current owner.
- gnt  output  4  registered one-hot grant; all zero when idle.
- out_valid  output  1  registered; high while any grant is active.
- out  output  DW  combinational mux of a/b/c/d by sel when out_valid=1, else all zero.

Behaviour:
- Reset (rst=1 at a rising edge):
  - sel=0, gnt=0, out_valid=0, out=0.
  - Internal last-owner pointer=3, so requester 0 has first priority after reset.
  - Hold counter=0; state=IDLE.
  - Reset overrides any request in the same cycle and drops an active grant immediately, mid-tenure included.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, remain IDLE with outputs at reset values. The last-owner pointer is retained.
  - If req!=0, choose the first set bit scanning last+1, last+2, last+3, last (mod 4).
  - At the next edge: gnt=onehot(choice), sel=choice, out_valid=1, hold counter=0, go to GRANT.
  - Grant latency is exactly 1 cycle from the edge that samples the request.
- GRANT, owner o, hold counter h. Evaluate at each edge in this order:
  - req[o]=0 and another req set: hand over to the round-robin choice scanning from o+1. No idle bubble; gnt changes directly from one one-hot value to the other. last=o, h=0.
  - req[o]=0 and no other req: go to IDLE. gnt=0, out_valid=0, last=o.
  - req[o]=1, other req set, and h==MAX_HOLD-1: forced rotation to the next requester from o+1. last=o, h=0.
  - req[o]=1 otherwise: keep o. h increments, saturating at MAX_HOLD-1.
- Hold counting:
  - h counts tenure cycles after the first.
  - An owner alone on the bus keeps the grant indefinitely; h saturates and causes no rotation.
  - With MAX_HOLD=1, ownership rotates every cycle whenever contention exists.
- Invariants:
  - gnt is always zero or one-hot.
  - sel equals the index of the set gnt bit.
  - When gnt=0, sel holds its last value but out is forced to zero.
  - out has no register stage; it follows a/b/c/d combinationally for the current sel.
- Simultaneous events:
  - A requester that rises in the same cycle the owner drops is eligible for that handover.
  - Ties are resolved only by the rotating scan; there is no fixed priority after reset.
- Fairness: with all four requesting continuously, each owner holds for exactly MAX_HOLD cycles, in order 0,1,2,3,0,...

Test Plan:
- Reset then single requester: rst=1 for 2 cycles, then req=4'b0100 with c=1. One cycle later gnt=4'b0100, sel=2, out_valid=1, out=1. Drop req; next cycle gnt=0, out=0.
- Post-reset priority: req=4'b1111 at the first cycle after reset, MAX_HOLD=4. Grant sequence is 0,1,2,3,0, each held exactly 4 cycles; sel follows 0,1,2,3,0.
- Back-to-back handover: owner 1 active, req changes 4'b0010 to 4'b1000 in one cycle. gnt goes 4'b0010 to 4'b1000 on the next edge with no cycle of out_valid=0.
- Solo owner saturation: req=4'b0001 for 20 cycles, MAX_HOLD=4. gnt stays 4'b0001 throughout. Then assert req[2]; requester 2 is granted at most 1 cycle after the request is sampled.
- Reset mid-tenure: owner 3 with h=2, assert rst for 1 cycle with req=4'b1111. Outputs become zero that edge. After release, requester 0 is granted first.
- Data path check: hold each grant, sweep {a,b,c,d} through 0..15 with DW=1. out always equals the input selected by sel, and is 0 whenever out_valid=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter and select sequencer for a shared 4:1 mux
//
// Purpose: decides which of four requesters owns a shared 4:1 mux, drives the
// registered select/grant, and produces the muxed data combinationally.
// Ownership rotates fairly; an owner is forced off after MAX_HOLD cycles of
// tenure only while somebody else is waiting.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req[3:0]   request lines, bit i belongs to requester i (a,b,c,d)
//   a,b,c,d    requester data words, DW bits each
//   sel[1:0]   registered index of the current owner
//   gnt[3:0]   registered one-hot grant, zero when idle
//   out_valid  registered, high while a grant is active
//   out        combinational mux of a/b/c/d by sel, zero when not valid

module mux4_rr_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [1:0]    sel,
    output logic [3:0]    gnt,
    output logic          out_valid,
    output logic [DW-1:0] out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      r_state, w_nxt_state;
    logic [1:0]  r_last,  w_nxt_last;
    logic [7:0]  r_hold,  w_nxt_hold;
    logic [1:0]  r_sel,   w_nxt_sel;
    logic [3:0]  r_gnt,   w_nxt_gnt;
    logic        r_valid, w_nxt_valid;

    logic [3:0]  w_others;
    logic [1:0]  w_idle_pick;
    logic [1:0]  w_next_owner;

    // First set bit of r scanning base+1, base+2, base+3, base. Iterating
    // from the farthest offset down lets the nearest hit overwrite the rest.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k + 1);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    // While granted, r_gnt is exactly the owner bit, so this is "everyone else".
    assign w_others     = req & ~r_gnt;
    assign w_idle_pick  = rr_pick(req, r_last);
    assign w_next_owner = rr_pick(w_others, r_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 2'd3;
            r_hold  <= 8'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_last  <= w_nxt_last;
            r_hold  <= w_nxt_hold;
            r_sel   <= w_nxt_sel;
            r_gnt   <= w_nxt_gnt;
            r_valid <= w_nxt_valid;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_last  = r_last;
        w_nxt_hold  = r_hold;
        w_nxt_sel   = r_sel;
        w_nxt_gnt   = r_gnt;
        w_nxt_valid = r_valid;

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_nxt_state = GRANT;
                    w_nxt_sel   = w_idle_pick;
                    w_nxt_gnt   = 4'b0001 << w_idle_pick;
                    w_nxt_valid = 1'b1;
                    w_nxt_hold  = 8'd0;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    w_nxt_last = r_sel;
                    w_nxt_hold = 8'd0;
                    if (|w_others) begin
                        // direct handover, no idle bubble
                        w_nxt_sel = w_next_owner;
                        w_nxt_gnt = 4'b0001 << w_next_owner;
                    end else begin
                        // sel keeps its value; out is gated by out_valid
                        w_nxt_state = IDLE;
                        w_nxt_gnt   = 4'd0;
                        w_nxt_valid = 1'b0;
                    end
                end else if ((|w_others) && (r_hold == HOLD_LAST)) begin
                    w_nxt_last = r_sel;
                    w_nxt_hold = 8'd0;
                    w_nxt_sel  = w_next_owner;
                    w_nxt_gnt  = 4'b0001 << w_next_owner;
                end else if (r_hold != HOLD_LAST) begin
                    // saturates so a lone owner never triggers rotation by itself
                    w_nxt_hold = r_hold + 8'd1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_comb begin
        out = '0;
        if (r_valid) begin
            case (r_sel)
                2'd0:    out = a;
                2'd1:    out = b;
                2'd2:    out = c;
                default: out = d;
            endcase
        end
    end

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter

module tb_mux4_rr_arbiter;

    localparam int DW       = 1;
    localparam int MAX_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = 4'd0;
    logic [DW-1:0] a = '0, b = '0, c = '0, d = '0;
    logic [1:0]    sel;
    logic [3:0]    gnt;
    logic          out_valid;
    logic [DW-1:0] out;

    int n_checks = 0;
    int n_errors = 0;

    // expected {gnt, sel, out_valid, out}
    logic [7:0] sb_q[$];
    logic [7:0] exp_v, obs_v;

    // reference model: owner (-1 = idle), last owner, tenure length in cycles
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_ten   = 0;

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .sel(sel), .gnt(gnt), .out_valid(out_valid), .out(out)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq);
        logic [3:0] oth;
        int nx;
        if (r) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_ten = 0;
        end else if (m_owner < 0) begin
            nx = pick(rq, m_last);
            if (nx >= 0) begin
                m_owner = nx; m_sel = nx; m_ten = 1;
            end
        end else begin
            oth = rq;
            oth[m_owner] = 1'b0;
            if (!rq[m_owner]) begin
                m_last = m_owner;
                nx = pick(oth, m_owner);
                if (nx >= 0) begin
                    m_owner = nx; m_sel = nx; m_ten = 1;
                end else begin
                    m_owner = -1;
                end
            end else if (oth != 4'd0 && m_ten >= MAX_HOLD) begin
                m_last = m_owner;
                nx = pick(oth, m_owner);
                m_owner = nx; m_sel = nx; m_ten = 1;
            end else begin
                m_ten++;
            end
        end
    endtask

    // Drives one cycle of stimulus, pushes the expected post-edge outputs,
    // then returns 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] abcd);
        logic [3:0] gx;
        logic       ox;
        @(negedge clk);
        rst = r; req = rq;
        a = abcd[0]; b = abcd[1]; c = abcd[2]; d = abcd[3];
        model_step(r, rq);
        gx = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'd0;
        ox = (m_owner >= 0) ? abcd[m_sel] : 1'b0;
        sb_q.push_back({gx, 2'(m_sel), (m_owner >= 0), ox});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b1111, 4'b1111);
            exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++; $display("FAIL reset_sb got=%h want=%h", obs_v, exp_v);
            end
        end
        n_checks++;
        if ({gnt, sel, out_valid, out} !== 8'd0) begin
            n_errors++; $display("FAIL reset_state got=%h want=00", {gnt, sel, out_valid, out});
        end
    endtask

    task automatic test_single();
        drive(1'b0, 4'b0100, 4'b0100);
        exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
        if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL single_sb got=%h want=%h", obs_v, exp_v);
        end
        n_checks++;
        if ({gnt, sel, out_valid, out} !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin
            n_errors++; $display("FAIL single_grant got=%h want=%h", {gnt, sel, out_valid, out}, 8'h4b);
        end
        drive(1'b0, 4'b0000, 4'b0100);
        exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
        if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL single_drop_sb got=%h want=%h", obs_v, exp_v);
        end
        n_checks++;
        if (gnt !== 4'd0 || out !== 1'b0) begin
            n_errors++; $display("FAIL single_drop gnt=%b out=%b want 0000/0", gnt, out);
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 4'b0000, 4'b0000);
        void'(sb_q.pop_front());
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'b1111, 4'($urandom_range(0, 15)));
            exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++; $display("FAIL priority_sb cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
            n_checks++;
            if (sel !== 2'((i / MAX_HOLD) % 4)) begin
                n_errors++; $display("FAIL priority_seq cyc=%0d sel=%0d want=%0d", i, sel, (i / MAX_HOLD) % 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'b0000, 4'b0000);
        void'(sb_q.pop_front());
        drive(1'b0, 4'b0010, 4'b0010);
        void'(sb_q.pop_front());
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_errors++; $display("FAIL b2b_owner1 gnt=%b want=0010", gnt);
        end
        drive(1'b0, 4'b1000, 4'b1000);
        exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
        if (obs_v !== exp_v) begin
            n_errors++; $display("FAIL b2b_sb got=%h want=%h", obs_v, exp_v);
        end
        n_checks++;
        if (gnt !== 4'b1000 || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL b2b_handover gnt=%b valid=%b want 1000/1", gnt, out_valid);
        end
    endtask

    task automatic test_solo_saturation();
        drive(1'b1, 4'b0000, 4'b0000);
        void'(sb_q.pop_front());
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'b0001, 4'($urandom_range(0, 15)));
            exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
            if (obs_v !== exp_v || gnt !== 4'b0001) begin
                n_errors++; $display("FAIL solo_hold cyc=%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
        drive(1'b0, 4'b0101, 4'b0100);
        exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
        if (obs_v !== exp_v || gnt !== 4'b0100) begin
            n_errors++; $display("FAIL solo_rotate got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_reset_mid_tenure();
        drive(1'b1, 4'b0000, 4'b0000);
        void'(sb_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b1000, 4'b1000);
            void'(sb_q.pop_front());
        end
        drive(1'b1, 4'b1111, 4'b1111);
        exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
        if (obs_v !== exp_v || obs_v !== 8'd0) begin
            n_errors++; $display("FAIL midrst_zero got=%h want=%h", obs_v, exp_v);
        end
        drive(1'b0, 4'b1111, 4'b1111);
        exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
        if (obs_v !== exp_v || gnt !== 4'b0001) begin
            n_errors++; $display("FAIL midrst_first got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_datapath();
        for (int o = 0; o < 5; o++) begin
            for (int v = 0; v < 16; v++) begin
                // o==4 sweeps data with nobody requesting
                drive(1'b0, (o < 4) ? (4'b0001 << o) : 4'b0000, 4'(v));
                exp_v = sb_q.pop_front(); obs_v = {gnt, sel, out_valid, out}; n_checks++;
                if (obs_v !== exp_v) begin
                    n_errors++; $display("FAIL datapath own=%0d v=%0d got=%h want=%h", o, v, obs_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_solo_saturation();
        test_reset_mid_tenure();
        test_datapath();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
